// File: rtl/branch_resolve_queue_if.sv
// Purpose: bus bundle between fetch/execute and the branch resolve queue.
//   Carries the alloc request, the resolve request, the predictor/BTB
//   training outputs and the redirect outputs.
// Modports:
//   master - fetch/execute side: drives alloc_* and resolve_*, observes the rest
//   slave  - queue side: observes alloc_* and resolve_*, drives the rest
interface brq_if #(
  parameter int unsigned W_A = 19
) ();
  logic           alloc_valid;
  logic           alloc_ready;
  logic [W_A-1:0] alloc_pc;
  logic           alloc_pred_taken;
  logic [W_A-1:0] alloc_pred_target;

  logic           resolve_valid;
  logic           resolve_taken;
  logic [W_A-1:0] resolve_target;
  logic           resolve_is_ret;

  logic           update;
  logic [W_A-1:0] update_pc;
  logic           rslt;
  logic [W_A-1:0] update_target;
  logic           update_read_ras;

  logic           redirect;
  logic [W_A-1:0] redirect_pc;

  modport master (
    output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
    output resolve_valid, resolve_taken, resolve_target, resolve_is_ret,
    input  alloc_ready,
    input  update, update_pc, rslt, update_target, update_read_ras,
    input  redirect, redirect_pc
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
    input  resolve_valid, resolve_taken, resolve_target, resolve_is_ret,
    output alloc_ready,
    output update, update_pc, rslt, update_target, update_read_ras,
    output redirect, redirect_pc
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// Purpose: in-order queue of in-flight branch predictions. Entries are
//   written at fetch and drained at execute resolution; each resolved
//   outcome trains the gshare predictor/BTB and a mispredict issues a
//   one-cycle redirect and flushes every younger entry.
// Ports:
//   CLK, RST  - clock, synchronous active-high reset
//   EN        - global stall; 0 holds all state and outputs
//   bus       - brq_if.slave: alloc, resolve, training and redirect signals
//   count     - number of valid entries
//   err       - sticky: resolve_valid seen while the queue was empty
// Optional feature (macro BRQ_STATS_EN): adds stat_resolved / stat_mispred
//   32-bit wrapping counters of accepted resolves and mispredicts.
module branch_resolve_queue #(
  parameter int unsigned W_A   = 19,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W_PTR = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  brq_if.slave             bus,
  output logic [W_PTR:0]   count,
  output logic             err
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]      stat_resolved,
  output logic [31:0]      stat_mispred
`endif
);

  localparam int unsigned CNT_W = W_PTR + 1;

  typedef struct packed {
    logic [W_A-1:0] pc;
    logic           pred_taken;
    logic [W_A-1:0] pred_target;
  } entry_t;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  entry_t             mem [DEPTH];
  logic [W_PTR-1:0]   head, tail;
  state_t             state, state_nxt;

  entry_t             head_e_c;
  logic               alloc_acc_c, res_acc_c, mispred_c, ready_nxt_c;
  logic [W_PTR-1:0]   head_nxt_c, tail_nxt_c;
  logic [CNT_W-1:0]   count_nxt_c;
  logic [W_A-1:0]     redirect_pc_c;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_RUN;
    else     state <= state_nxt;
  end

  // Next state, accept decode, pointer/count update and mispredict detection
  always_comb begin
    state_nxt   = state;
    head_e_c    = mem[head];
    head_nxt_c  = head;
    tail_nxt_c  = tail;
    count_nxt_c = count;

    alloc_acc_c = EN && bus.alloc_valid && bus.alloc_ready;
    res_acc_c   = EN && bus.resolve_valid && (count != '0);
    mispred_c   = res_acc_c &&
                  ((head_e_c.pred_taken != bus.resolve_taken) ||
                   (bus.resolve_taken && (head_e_c.pred_target != bus.resolve_target)));
    redirect_pc_c = bus.resolve_taken ? bus.resolve_target
                                      : W_A'(head_e_c.pc + W_A'(4));

    if (mispred_c) begin
      // Full flush: a same-cycle alloc is dropped along with all younger entries
      state_nxt   = S_FLUSH;
      head_nxt_c  = '0;
      tail_nxt_c  = '0;
      count_nxt_c = '0;
    end else begin
      if (EN && (state == S_FLUSH)) state_nxt = S_RUN;
      if (alloc_acc_c) begin
        tail_nxt_c  = W_PTR'(tail + W_PTR'(1));
        count_nxt_c = CNT_W'(count_nxt_c + CNT_W'(1));
      end
      if (res_acc_c) begin
        head_nxt_c  = W_PTR'(head + W_PTR'(1));
        count_nxt_c = CNT_W'(count_nxt_c - CNT_W'(1));
      end
    end

    // alloc_ready is registered from the next state/count, so no bypass exists
    ready_nxt_c = (state_nxt == S_RUN) && (count_nxt_c < CNT_W'(DEPTH));
  end

  // Entry storage; contents are only meaningful while counted as valid
  always_ff @(posedge CLK) begin
    if (!RST && alloc_acc_c && !mispred_c) begin
      mem[tail] <= '{pc:          bus.alloc_pc,
                     pred_taken:  bus.alloc_pred_taken,
                     pred_target: bus.alloc_pred_target};
    end
  end

  // Pointers, count and all registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      head                <= '0;
      tail                <= '0;
      count               <= '0;
      err                 <= 1'b0;
      bus.alloc_ready     <= 1'b1;
      bus.update          <= 1'b0;
      bus.update_pc       <= '0;
      bus.rslt            <= 1'b0;
      bus.update_target   <= '0;
      bus.update_read_ras <= 1'b0;
      bus.redirect        <= 1'b0;
      bus.redirect_pc     <= '0;
    end else if (EN) begin
      head            <= head_nxt_c;
      tail            <= tail_nxt_c;
      count           <= count_nxt_c;
      bus.alloc_ready <= ready_nxt_c;
      bus.update      <= res_acc_c;
      bus.redirect    <= mispred_c;
      if (bus.resolve_valid && (count == '0)) err <= 1'b1;
      if (res_acc_c) begin
        bus.update_pc       <= head_e_c.pc;
        bus.rslt            <= bus.resolve_taken;
        bus.update_target   <= bus.resolve_target;
        bus.update_read_ras <= bus.resolve_is_ret;
      end
      if (mispred_c) bus.redirect_pc <= redirect_pc_c;
    end
  end

`ifdef BRQ_STATS_EN
  // Resolve / mispredict statistics, wrapping at 2^32
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else if (EN) begin
      if (res_acc_c) stat_resolved <= stat_resolved + 32'd1;
      if (mispred_c) stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Purpose: self-checking bench for branch_resolve_queue. Directed steps
//   followed by a randomized phase, all compared every cycle against a
//   queue-based reference model.
module tb_branch_resolve_queue;
  localparam int unsigned W_A   = 19;
  localparam int unsigned DEPTH = 8;
  localparam logic [W_A-1:0] MASK = '1;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [3:0] count;
  logic       err;
`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif

  always #5 CLK = ~CLK;

  brq_if #(.W_A(W_A)) bus ();

  branch_resolve_queue #(.W_A(W_A), .DEPTH(DEPTH), .W_PTR(3)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (EN),
    .bus   (bus),
    .count (count),
    .err   (err)
`ifdef BRQ_STATS_EN
    ,
    .stat_resolved (stat_resolved),
    .stat_mispred  (stat_mispred)
`endif
  );

  // Reference model state
  typedef struct {
    logic [W_A-1:0] pc;
    logic           pt;
    logic [W_A-1:0] tgt;
  } ent_t;

  ent_t           mq[$];
  logic           m_flush, m_update, m_rslt, m_ras, m_redir, m_err;
  logic [W_A-1:0] m_upc, m_utgt, m_rpc;
  logic [31:0]    m_nres, m_nmis;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic av, input logic [W_A-1:0] apc, input logic apt,
                        input logic [W_A-1:0] atgt, input logic rv, input logic rt,
                        input logic [W_A-1:0] rtgt, input logic rret);
    bus.alloc_valid       = av;
    bus.alloc_pc          = apc;
    bus.alloc_pred_taken  = apt;
    bus.alloc_pred_target = atgt;
    bus.resolve_valid     = rv;
    bus.resolve_taken     = rt;
    bus.resolve_target    = rtgt;
    bus.resolve_is_ret    = rret;
  endtask

  task automatic idle();
    set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Advances the model by one clock edge using the currently driven inputs
  task automatic model_step();
    logic ready, racc, aacc, mis;
    if (RST) begin
      mq.delete();
      m_flush = 0; m_update = 0; m_rslt = 0; m_ras = 0; m_redir = 0; m_err = 0;
      m_upc = '0; m_utgt = '0; m_rpc = '0; m_nres = 0; m_nmis = 0;
    end else if (EN) begin
      ready = !m_flush && (mq.size() < DEPTH);
      racc  = bus.resolve_valid && (mq.size() > 0);
      aacc  = bus.alloc_valid && ready;
      mis   = 1'b0;
      if (bus.resolve_valid && mq.size() == 0) m_err = 1'b1;
      m_update = racc;
      if (racc) begin
        m_upc  = mq[0].pc;
        m_rslt = bus.resolve_taken;
        m_utgt = bus.resolve_target;
        m_ras  = bus.resolve_is_ret;
        mis = (mq[0].pt != bus.resolve_taken) ||
              (bus.resolve_taken && mq[0].tgt != bus.resolve_target);
        m_nres++;
      end
      m_redir = mis;
      m_flush = mis;
      if (mis) begin
        m_rpc = bus.resolve_taken ? bus.resolve_target : ((mq[0].pc + 19'd4) & MASK);
        m_nmis++;
        mq.delete();
      end else begin
        if (racc) void'(mq.pop_front());
        if (aacc) mq.push_back('{pc: bus.alloc_pc, pt: bus.alloc_pred_taken,
                                 tgt: bus.alloc_pred_target});
      end
    end
  endtask

  task automatic check_all();
    chk("count",           32'(count),               32'(mq.size()));
    chk("alloc_ready",     32'(bus.alloc_ready),     32'(!m_flush && mq.size() < DEPTH));
    chk("update",          32'(bus.update),          32'(m_update));
    chk("update_pc",       32'(bus.update_pc),       32'(m_upc));
    chk("rslt",            32'(bus.rslt),            32'(m_rslt));
    chk("update_target",   32'(bus.update_target),   32'(m_utgt));
    chk("update_read_ras", 32'(bus.update_read_ras), 32'(m_ras));
    chk("redirect",        32'(bus.redirect),        32'(m_redir));
    chk("redirect_pc",     32'(bus.redirect_pc),     32'(m_rpc));
    chk("err",             32'(err),                 32'(m_err));
`ifdef BRQ_STATS_EN
    chk("stat_resolved",   stat_resolved,            m_nres);
    chk("stat_mispred",    stat_mispred,             m_nmis);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  initial begin
    RST = 1'b1;
    EN  = 1'b1;
    idle();
    tick();
    RST = 1'b0;

    // Reset then idle
    tick();
    chk("rst_ready",    32'(bus.alloc_ready), 32'd1);
    chk("rst_count",    32'(count),           32'd0);
    chk("rst_redirect", 32'(bus.redirect),    32'd0);

    // Correct taken prediction
    set_in(1'b1, 19'h100, 1'b1, 19'h200, 1'b0, 1'b0, '0, 1'b0); tick();
    set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 19'h200, 1'b0);      tick();
    chk("hit_update",   32'(bus.update),        32'd1);
    chk("hit_pc",       32'(bus.update_pc),     32'h100);
    chk("hit_rslt",     32'(bus.rslt),          32'd1);
    chk("hit_target",   32'(bus.update_target), 32'h200);
    chk("hit_redirect", 32'(bus.redirect),      32'd0);
    chk("hit_count",    32'(count),             32'd0);

    // Fill to full, then resolve with a rejected simultaneous alloc
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 19'(32'h1000 + 4 * i), 1'b0, 19'h0, 1'b0, 1'b0, '0, 1'b0);
      tick();
    end
    chk("full_count", 32'(count),           32'd8);
    chk("full_ready", 32'(bus.alloc_ready), 32'd0);
    set_in(1'b1, 19'h2000, 1'b0, 19'h0, 1'b1, 1'b0, 19'h0, 1'b1); tick();
    chk("full_res_count", 32'(count),               32'd7);
    chk("full_res_ras",   32'(bus.update_read_ras), 32'd1);
    for (int i = 0; i < 7; i++) begin
      set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 19'h0, 1'b0);
      tick();
    end
    chk("drain_count", 32'(count), 32'd0);

    // Not-taken mispredict flushes younger entries
    set_in(1'b1, 19'h40, 1'b1, 19'h80, 1'b0, 1'b0, '0, 1'b0); tick();
    set_in(1'b1, 19'h80, 1'b0, 19'h0,  1'b0, 1'b0, '0, 1'b0); tick();
    set_in(1'b1, 19'h84, 1'b0, 19'h0,  1'b0, 1'b0, '0, 1'b0); tick();
    set_in(1'b1, 19'h90, 1'b0, 19'h0,  1'b1, 1'b0, 19'h0, 1'b0); tick();
    chk("mis_redirect", 32'(bus.redirect),    32'd1);
    chk("mis_rpc",      32'(bus.redirect_pc), 32'h44);
    chk("mis_count",    32'(count),           32'd0);
    chk("mis_ready",    32'(bus.alloc_ready), 32'd0);
    chk("mis_rslt",     32'(bus.rslt),        32'd0);
    set_in(1'b1, 19'h90, 1'b0, 19'h0, 1'b0, 1'b0, '0, 1'b0); tick();
    chk("flush_drop_count", 32'(count),           32'd0);
    chk("flush_end_ready",  32'(bus.alloc_ready), 32'd1);
    chk("flush_end_redir",  32'(bus.redirect),    32'd0);
    idle(); tick();

    // Wrong target mispredict
    set_in(1'b1, 19'h500, 1'b1, 19'h280, 1'b0, 1'b0, '0, 1'b0); tick();
    set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 19'h300, 1'b0);      tick();
    chk("tgt_rpc", 32'(bus.redirect_pc), 32'h300);
    idle(); tick();

    // Fall-through pc wraps
    set_in(1'b1, 19'h7FFFC, 1'b1, 19'h10, 1'b0, 1'b0, '0, 1'b0); tick();
    set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 19'h0, 1'b0);         tick();
    chk("wrap_redir", 32'(bus.redirect),    32'd1);
    chk("wrap_rpc",   32'(bus.redirect_pc), 32'h0);
    idle(); tick();

    // Resolve on empty queue
    set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 19'h5, 1'b0); tick();
    chk("empty_update", 32'(bus.update), 32'd0);
    chk("empty_err",    32'(err),        32'd1);
    idle(); tick();
    chk("err_sticky", 32'(err), 32'd1);

    // Stall holds a pending update pulse
    set_in(1'b1, 19'h600, 1'b0, 19'h0, 1'b0, 1'b0, '0, 1'b0); tick();
    set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 19'h0, 1'b0);      tick();
    EN = 1'b0;
    set_in(1'b1, 19'h700, 1'b0, 19'h0, 1'b1, 1'b0, 19'h0, 1'b0);
    tick(); tick();
    chk("stall_update", 32'(bus.update), 32'd1);
    chk("stall_pc",     32'(bus.update_pc), 32'h600);
    EN = 1'b1;
    idle(); tick();
    chk("stall_release", 32'(bus.update), 32'd0);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      logic           rt;
      logic [W_A-1:0] rtgt;
      RST = ($urandom_range(0, 299) == 0);
      EN  = ($urandom_range(0, 9) != 0);
      rt   = 1'($urandom);
      rtgt = 19'($urandom_range(0, 3) * 16);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt   = mq[0].pt;
        rtgt = mq[0].tgt;
      end
      set_in(($urandom_range(0, 2) != 0), 19'($urandom), 1'($urandom),
             19'($urandom_range(0, 3) * 16),
             ($urandom_range(0, 2) == 0), rt, rtgt, 1'($urandom));
      tick();
    end
    RST = 1'b0;
    EN  = 1'b1;
    idle(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
